// File: rtl/nf_cu_mc.sv
// nf_cu_mc -- multi-cycle control unit for a small RV32I subset.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for ADD, SUB, OR, SLLI,
// ADDI, LUI, BEQ, BNE, LW, SW and JAL. Both the fetch and the data access
// are bounded by a timeout. When the timeout expires, the unit parks in a
// terminal ERR state with bus_err set, and only rst clears it.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   instr                fetched word, valid while i_ack=1
//   i_req / i_ack        instruction fetch handshake
//   d_req / d_we / d_ack data access handshake (d_we=1 for stores)
//   zero                 ALU result-is-zero flag, used by branches in EXEC
//   ir_we, pc_we, rf_we  single-cycle write strobes
//   pc_src               00 pc+4, 01 branch target, 10 jump target
//   wd_src               00 ALU, 01 memory, 10 pc+4
//   imm_src, jal_imm     immediate select: I=00 U=01 B=10 S=11; J via jal_imm
//   srcBsel, ALU_Code    ALU operand-B select (1 = immediate) and operation
//   illegal, bus_err     sticky error flags
//   state                current FSM encoding
//
// Build option: define NF_CU_TRAP_EN to send undecoded instructions to ERR
// with illegal=1. Without it, they retire as NOPs and illegal is tied 0.
module nf_cu_mc #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_CODE_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    output logic                  i_req,
    input  logic                  i_ack,
    output logic                  d_req,
    output logic                  d_we,
    input  logic                  d_ack,
    input  logic                  zero,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  rf_we,
    output logic [1:0]            pc_src,
    output logic [1:0]            wd_src,
    output logic [1:0]            imm_src,
    output logic                  jal_imm,
    output logic                  srcBsel,
    output logic [ALU_CODE_W-1:0] ALU_Code,
    output logic                  illegal,
    output logic                  bus_err,
    output logic [2:0]            state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = ALU_CODE_W'(0);
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = ALU_CODE_W'(1);
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = ALU_CODE_W'(2);
    localparam logic [ALU_CODE_W-1:0] ALU_SLL   = ALU_CODE_W'(3);
    localparam logic [ALU_CODE_W-1:0] ALU_PASSB = ALU_CODE_W'(4);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
    logic [6:0]       irOpcode_q, opcode_q;
    logic [2:0]       irFunct3_q, funct3_q;
    logic [6:0]       irFunct7_q, funct7_q;
    logic             bus_err_q, setBusErr;
`ifdef NF_CU_TRAP_EN
    logic             illegal_q, setIllegal;
`endif

    // Only opcode/funct3/funct7 steer control; the register and immediate
    // fields are consumed by the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    logic isAdd, isSub, isOr, isSlli, isAddi, isLui;
    logic isBeq, isBne, isLoad, isStore, isJal, isAlu;

    assign isAdd   = (opcode_q == OP_R) && (funct3_q == 3'b000) && (funct7_q == 7'b0000000);
    assign isSub   = (opcode_q == OP_R) && (funct3_q == 3'b000) && (funct7_q == 7'b0100000);
    assign isOr    = (opcode_q == OP_R) && (funct3_q == 3'b110) && (funct7_q == 7'b0000000);
    assign isSlli  = (opcode_q == OP_I) && (funct3_q == 3'b001) && (funct7_q == 7'b0000000);
    assign isAddi  = (opcode_q == OP_I) && (funct3_q == 3'b000);
    assign isLui   = (opcode_q == OP_LUI);
    assign isBeq   = (opcode_q == OP_BRANCH) && (funct3_q == 3'b000);
    assign isBne   = (opcode_q == OP_BRANCH) && (funct3_q == 3'b001);
    assign isLoad  = (opcode_q == OP_LOAD)   && (funct3_q == 3'b010);
    assign isStore = (opcode_q == OP_STORE)  && (funct3_q == 3'b010);
    assign isJal   = (opcode_q == OP_JAL);
    assign isAlu   = isAdd | isSub | isOr | isSlli | isAddi | isLui;

    assign cntInc = cnt_q + CNT_W'(1);

    // ALU and immediate controls follow the decoded instruction. They are
    // not strobes, so they stay valid across EXEC, MEM and WB. This keeps
    // the datapath's view of the current instruction stable throughout.
    always_comb begin
        ALU_Code = ALU_ADD;
        srcBsel  = 1'b0;
        imm_src  = 2'b00;
        jal_imm  = isJal;
        if (isSub || isBeq || isBne) ALU_Code = ALU_SUB;
        if (isOr)                    ALU_Code = ALU_OR;
        if (isSlli)                  ALU_Code = ALU_SLL;
        if (isLui)                   ALU_Code = ALU_PASSB;
        if (isAddi || isSlli || isLui || isLoad || isStore) srcBsel = 1'b1;
        if (isLui)                   imm_src = 2'b01;
        if (isBeq || isBne)          imm_src = 2'b10;
        if (isStore)                 imm_src = 2'b11;
    end

    // Next-state and strobe logic. The timeout counter only counts in FETCH
    // and MEM and is zero in every other state, so entering either state
    // starts it from 0. The ack is checked before the timeout compare, so an
    // ack in the cycle the count reaches MEM_TIMEOUT wins. All strobes and
    // requests are forced low while rst is high, which aborts the operation
    // in flight without a partial write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        setBusErr = 1'b0;
`ifdef NF_CU_TRAP_EN
        setIllegal = 1'b0;
`endif
        i_req  = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        rf_we  = 1'b0;
        pc_src = 2'b00;
        wd_src = 2'b00;

        case (state_q)
            FETCH: begin
                i_req = 1'b1;
                if (i_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else begin
                    cnt_d = cntInc;
                    if (cntInc == TIMEOUT_VAL) begin
                        state_d   = ERR;
                        setBusErr = 1'b1;
                    end
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (isAlu) begin
                    state_d = WB;
                end else if (isBeq || isBne) begin
                    pc_we   = 1'b1;
                    pc_src  = (zero ^ isBne) ? 2'b01 : 2'b00;
                    state_d = FETCH;
                end else if (isLoad || isStore) begin
                    state_d = MEM;
                end else if (isJal) begin
                    state_d = WB;
                end else begin
`ifdef NF_CU_TRAP_EN
                    state_d    = ERR;
                    setIllegal = 1'b1;
`else
                    pc_we   = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
            MEM: begin
                d_req = 1'b1;
                d_we  = isStore;
                if (d_ack) begin
                    if (isStore) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    cnt_d = cntInc;
                    if (cntInc == TIMEOUT_VAL) begin
                        state_d   = ERR;
                        setBusErr = 1'b1;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_src  = isJal ? 2'b10 : 2'b00;
                wd_src  = isJal ? 2'b10 : (isLoad ? 2'b01 : 2'b00);
                state_d = FETCH;
            end
            ERR:     state_d = ERR;
            default: state_d = FETCH;
        endcase

        if (rst) begin
            i_req = 1'b0;
            d_req = 1'b0;
            d_we  = 1'b0;
            ir_we = 1'b0;
            pc_we = 1'b0;
            rf_we = 1'b0;
        end
    end

    // State, counter and instruction field registers. The fields are
    // captured on the fetch handshake because instr is only valid during
    // i_ack. DECODE then copies them into the registers that steer EXEC
    // onward. The error flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            cnt_q      <= '0;
            irOpcode_q <= '0;
            irFunct3_q <= '0;
            irFunct7_q <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            bus_err_q  <= 1'b0;
`ifdef NF_CU_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_we) begin
                irOpcode_q <= instr[6:0];
                irFunct3_q <= instr[14:12];
                irFunct7_q <= instr[31:25];
            end
            if (state_q == DECODE) begin
                opcode_q <= irOpcode_q;
                funct3_q <= irFunct3_q;
                funct7_q <= irFunct7_q;
            end
            if (setBusErr) bus_err_q <= 1'b1;
`ifdef NF_CU_TRAP_EN
            if (setIllegal) illegal_q <= 1'b1;
`endif
        end
    end

    assign bus_err = bus_err_q;
    assign state   = state_q;
`ifdef NF_CU_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_nf_cu_mc.sv
// tb_nf_cu_mc -- directed testbench for nf_cu_mc.
// Walks ALU ops, branches, loads/stores, the data timeout and its boundary,
// an undecoded word, JAL, and a reset taken in the middle of JAL's WB.
module tb_nf_cu_mc;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SLLI = 32'h00309093;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        i_ack, d_ack, zero;
    logic        i_req, d_req, d_we, ir_we, pc_we, rf_we, jal_imm, srcBsel;
    logic [1:0]  pc_src, wd_src, imm_src;
    logic [3:0]  ALU_Code;
    logic        illegal, bus_err;
    logic [2:0]  state;

    int testsRun    = 0;
    int testsFailed = 0;

    nf_cu_mc #(.MEM_TIMEOUT(15), .ALU_CODE_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .i_req(i_req), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_ack(d_ack),
        .zero(zero),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .pc_src(pc_src), .wd_src(wd_src), .imm_src(imm_src),
        .jal_imm(jal_imm), .srcBsel(srcBsel), .ALU_Code(ALU_Code),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, then let combinational outputs settle before checks
    task automatic applyStimulus(input logic r, input logic ia, input logic da,
                                 input logic z, input logic [31:0] ins);
        rst   = r;
        i_ack = ia;
        d_ack = da;
        zero  = z;
        instr = ins;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack immediately, pass DECODE, return positioned in EXEC
    task automatic fetchDecode(input string tag, input logic [31:0] ins);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, ins);
        checkOutput({tag, " ir_we"}, 32'(ir_we), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, " decode"}, 32'(state), 32'd1);
        tick();
    endtask

    // Register-writing ALU op: EXEC controls, then WB strobes
    task automatic execAlu(input string tag, input logic [31:0] ins,
                           input logic [3:0] alu, input logic srcB,
                           input logic [1:0] imm);
        fetchDecode(tag, ins);
        checkOutput({tag, " exec state"}, 32'(state), 32'd2);
        checkOutput({tag, " ALU_Code"}, 32'(ALU_Code), 32'(alu));
        checkOutput({tag, " srcBsel"}, 32'(srcBsel), 32'(srcB));
        checkOutput({tag, " imm_src"}, 32'(imm_src), 32'(imm));
        tick();
        checkOutput({tag, " wb state"}, 32'(state), 32'd4);
        checkOutput({tag, " wb rf_we"}, 32'(rf_we), 32'd1);
        checkOutput({tag, " wb wd_src"}, 32'(wd_src), 32'd0);
        tick();
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("in rst pc_we", 32'(pc_we), 32'd0);

        // First cycle with rst low
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst state", 32'(state), 32'd0);
        checkOutput("rst i_req", 32'(i_req), 32'd1);
        checkOutput("rst d_req", 32'(d_req), 32'd0);
        checkOutput("rst d_we", 32'(d_we), 32'd0);
        checkOutput("rst ir_we", 32'(ir_we), 32'd0);
        checkOutput("rst pc_we", 32'(pc_we), 32'd0);
        checkOutput("rst rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst pc_src", 32'(pc_src), 32'd0);
        checkOutput("rst wd_src", 32'(wd_src), 32'd0);
        checkOutput("rst illegal", 32'(illegal), 32'd0);
        checkOutput("rst bus_err", 32'(bus_err), 32'd0);

        // ADDI with i_ack after two waiting fetch cycles
        tick();
        checkOutput("addi wait ir_we", 32'(ir_we), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, I_ADDI);
        checkOutput("addi fetch state", 32'(state), 32'd0);
        checkOutput("addi ir_we", 32'(ir_we), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("addi decode", 32'(state), 32'd1);
        checkOutput("addi decode ir_we", 32'(ir_we), 32'd0);
        tick();
        checkOutput("addi exec", 32'(state), 32'd2);
        checkOutput("addi ALU_Code", 32'(ALU_Code), 32'd0);
        checkOutput("addi srcBsel", 32'(srcBsel), 32'd1);
        checkOutput("addi exec rf_we", 32'(rf_we), 32'd0);
        checkOutput("addi exec pc_we", 32'(pc_we), 32'd0);
        tick();
        checkOutput("addi wb", 32'(state), 32'd4);
        checkOutput("addi wb rf_we", 32'(rf_we), 32'd1);
        checkOutput("addi wb pc_we", 32'(pc_we), 32'd1);
        checkOutput("addi wb wd_src", 32'(wd_src), 32'd0);
        tick();
        checkOutput("addi back fetch", 32'(state), 32'd0);
        checkOutput("addi after rf_we", 32'(rf_we), 32'd0);
        checkOutput("addi after pc_we", 32'(pc_we), 32'd0);

        execAlu("sub",  I_SUB,  4'd1, 1'b0, 2'b00);
        execAlu("or",   I_OR,   4'd2, 1'b0, 2'b00);
        execAlu("slli", I_SLLI, 4'd3, 1'b1, 2'b00);
        execAlu("lui",  I_LUI,  4'd4, 1'b1, 2'b01);

        // BNE zero=0 -> taken
        fetchDecode("bne0", I_BNE);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bne0 exec", 32'(state), 32'd2);
        checkOutput("bne0 pc_we", 32'(pc_we), 32'd1);
        checkOutput("bne0 pc_src", 32'(pc_src), 32'd1);
        checkOutput("bne0 rf_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("bne0 next", 32'(state), 32'd0);
        checkOutput("bne0 next pc_we", 32'(pc_we), 32'd0);

        // BNE zero=1 -> not taken
        fetchDecode("bne1", I_BNE);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("bne1 pc_we", 32'(pc_we), 32'd1);
        checkOutput("bne1 pc_src", 32'(pc_src), 32'd0);
        checkOutput("bne1 rf_we", 32'(rf_we), 32'd0);
        tick();

        // BEQ zero=1 -> taken
        fetchDecode("beq1", I_BEQ);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("beq1 pc_src", 32'(pc_src), 32'd1);
        checkOutput("beq1 imm_src", 32'(imm_src), 32'd2);
        tick();
        checkOutput("beq1 next", 32'(state), 32'd0);

        // LW with d_ack on the third MEM cycle; stray i_ack in MEM ignored
        fetchDecode("lw", I_LW);
        checkOutput("lw ALU_Code", 32'(ALU_Code), 32'd0);
        checkOutput("lw srcBsel", 32'(srcBsel), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("lw mem1 state", 32'(state), 32'd3);
        checkOutput("lw mem1 d_req", 32'(d_req), 32'd1);
        checkOutput("lw mem1 d_we", 32'(d_we), 32'd0);
        checkOutput("lw mem1 ir_we", 32'(ir_we), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("lw mem2 d_req", 32'(d_req), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("lw mem3 d_req", 32'(d_req), 32'd1);
        checkOutput("lw mem3 d_we", 32'(d_we), 32'd0);
        checkOutput("lw mem3 rf_we", 32'(rf_we), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("lw wb state", 32'(state), 32'd4);
        checkOutput("lw wb wd_src", 32'(wd_src), 32'd1);
        checkOutput("lw wb rf_we", 32'(rf_we), 32'd1);
        tick();
        checkOutput("lw next", 32'(state), 32'd0);

        // SW with d_ack exactly on the 15th MEM cycle: ack wins
        fetchDecode("swack", I_SW);
        checkOutput("swack imm_src", 32'(imm_src), 32'd3);
        tick();
        checkOutput("swack d_we", 32'(d_we), 32'd1);
        for (int i = 0; i < 14; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("swack mem15 state", 32'(state), 32'd3);
        checkOutput("swack pc_we", 32'(pc_we), 32'd1);
        checkOutput("swack pc_src", 32'(pc_src), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("swack next", 32'(state), 32'd0);
        checkOutput("swack bus_err", 32'(bus_err), 32'd0);

        // SW with no d_ack: ERR after 15 MEM cycles
        fetchDecode("swto", I_SW);
        tick();
        for (int i = 0; i < 15; i++) begin
            checkOutput("swto in mem", 32'(state), 32'd3);
            tick();
        end
        checkOutput("swto err state", 32'(state), 32'd5);
        checkOutput("swto bus_err", 32'(bus_err), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("swto err d_req", 32'(d_req), 32'd0);
        checkOutput("swto err i_req", 32'(i_req), 32'd0);
        checkOutput("swto err ir_we", 32'(ir_we), 32'd0);
        checkOutput("swto err pc_we", 32'(pc_we), 32'd0);
        tick();
        tick();
        checkOutput("swto sticky state", 32'(state), 32'd5);
        checkOutput("swto sticky bus_err", 32'(bus_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("swto rst pc_we", 32'(pc_we), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("swto cleared state", 32'(state), 32'd0);
        checkOutput("swto cleared bus_err", 32'(bus_err), 32'd0);
        checkOutput("swto cleared i_req", 32'(i_req), 32'd1);

        // Undecoded instruction
        fetchDecode("bad", I_BAD);
`ifdef NF_CU_TRAP_EN
        checkOutput("bad exec pc_we", 32'(pc_we), 32'd0);
        tick();
        checkOutput("bad err state", 32'(state), 32'd5);
        checkOutput("bad illegal", 32'(illegal), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bad cleared illegal", 32'(illegal), 32'd0);
`else
        checkOutput("bad nop pc_we", 32'(pc_we), 32'd1);
        checkOutput("bad nop pc_src", 32'(pc_src), 32'd0);
        checkOutput("bad nop rf_we", 32'(rf_we), 32'd0);
        checkOutput("bad illegal", 32'(illegal), 32'd0);
        tick();
        checkOutput("bad back fetch", 32'(state), 32'd0);
`endif

        // JAL completing normally
        fetchDecode("jal", I_JAL);
        checkOutput("jal exec state", 32'(state), 32'd2);
        checkOutput("jal jal_imm", 32'(jal_imm), 32'd1);
        tick();
        checkOutput("jal wb state", 32'(state), 32'd4);
        checkOutput("jal wb wd_src", 32'(wd_src), 32'd2);
        checkOutput("jal wb pc_src", 32'(pc_src), 32'd2);
        checkOutput("jal wb rf_we", 32'(rf_we), 32'd1);
        tick();

        // JAL with rst asserted in WB: no write
        fetchDecode("jalrst", I_JAL);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("jalrst wb state", 32'(state), 32'd4);
        checkOutput("jalrst rf_we", 32'(rf_we), 32'd0);
        checkOutput("jalrst pc_we", 32'(pc_we), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("jalrst after state", 32'(state), 32'd0);
        checkOutput("jalrst after i_req", 32'(i_req), 32'd1);
        checkOutput("jalrst after rf_we", 32'(rf_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/nf_cu_mc.md
NF_CU_MC -- requirements
Module: nf_cu_mc

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of cycles to wait for i_ack/d_ack before a bus error.
REQ-002 SHALL have parameter ALU_CODE_W, default 4: width of ALU_Code.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port instr, input, 32 bits: the fetched instruction word, valid when i_ack=1.
REQ-006 SHALL have port i_req, output, 1 bit: instruction fetch request. Port i_ack, input, 1 bit: fetch done.
REQ-007 SHALL have port d_req, output, 1 bit: data access request. Port d_we, output, 1 bit: store. Port d_ack, input, 1 bit: data access done.
REQ-008 SHALL have port zero, input, 1 bit: ALU result-equals-zero flag, sampled in EXEC.
REQ-009 SHALL have these datapath controls, all outputs:
- ir_we, 1 bit; pc_we, 1 bit; rf_we, 1 bit.
- pc_src, 2 bits: 00 pc+4, 01 branch target, 10 jump target.
- wd_src, 2 bits: 00 ALU, 01 memory, 10 pc+4.
- imm_src, 2 bits: I/U/B/S/J select shares 2 bits plus jal_imm, 1 bit.
- srcBsel, 1 bit; ALU_Code, ALU_CODE_W bits.
REQ-010 SHALL have status outputs illegal, 1 bit; bus_err, 1 bit; state, 3 bits (current FSM encoding).

Function
REQ-011 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.
REQ-012 FETCH SHALL:
- hold i_req=1;
- on i_ack, pulse ir_we for that same cycle and go to DECODE.
REQ-013 DECODE SHALL:
- take one cycle;
- register opcode, funct3 and funct7 from the instruction register;
- go to EXEC.
REQ-014 SHALL decode ADD, SUB, OR, SLLI, ADDI, LUI, BEQ, BNE (funct3=001), LW (0000011/010), SW (0100011/010) and JAL (1101111).
REQ-015 In EXEC, R/I/LUI SHALL drive ALU_Code and srcBsel, then go to WB.
REQ-016 In EXEC, BEQ/BNE SHALL:
- assert pc_we;
- set pc_src=01 when (zero XOR BNE) is true, else 00;
- go to FETCH.
REQ-017 In EXEC, LW/SW SHALL compute the address with ALU add and go to MEM.
REQ-018 In EXEC, JAL SHALL go to WB with wd_src=10, pc_src=10 and jal_imm=1.
REQ-019 MEM SHALL:
- hold d_req=1, with d_we=1 for SW only;
- on d_ack, SW asserts pc_we (pc_src=00) and goes to FETCH;
- on d_ack, LW goes to WB with wd_src=01.
REQ-020 WB SHALL assert rf_we and pc_we for exactly one cycle, then go to FETCH.
REQ-021 SHALL keep a timeout counter that clears on entry to FETCH/MEM and increments each cycle without an ack.
REQ-022 When the timeout counter reaches MEM_TIMEOUT, the FSM SHALL go to ERR with bus_err=1.
REQ-023 An ack arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win: no error is raised.
REQ-024 ERR SHALL be terminal: all enables and requests 0, and bus_err/illegal held until rst.
REQ-025 Every write strobe (ir_we, pc_we, rf_we) SHALL be at most a single-cycle pulse per instruction; none SHALL be asserted outside the states listed above.
REQ-026 i_ack in non-FETCH states and d_ack outside MEM SHALL be ignored.

Reset
REQ-027 While rst=1, the next state SHALL be FETCH and the timeout counter SHALL be 0.
REQ-028 In the cycle after rst deasserts, outputs SHALL be:
- i_req=1;
- d_req=0, d_we=0, ir_we=0, pc_we=0, rf_we=0;
- pc_src=00, wd_src=00, illegal=0, bus_err=0, state=0.
REQ-029 rst asserted mid-MEM or in ERR SHALL abort the operation with no strobe issued in that cycle.

Configuration
REQ-030 With macro NF_CU_TRAP_EN defined, an undecoded instruction in EXEC SHALL go to ERR with illegal=1.
REQ-031 Without NF_CU_TRAP_EN, an undecoded instruction SHALL execute as a NOP: pc_we=1, pc_src=00, go to FETCH; illegal SHALL be tied 0.

Verification
REQ-032 ADDI with i_ack after 2 cycles -> ir_we pulse, then DECODE, EXEC, WB; rf_we and pc_we high together for 1 cycle; 5 cycles total.
REQ-033 BNE with zero=0, then with zero=1 -> pc_src=01 then 00; pc_we pulses in EXEC; rf_we never asserted.
REQ-034 LW with d_ack after 3 cycles -> d_req=1 and d_we=0 for 3 cycles; WB with wd_src=01 and rf_we=1.
REQ-035 SW with d_ack never asserted, MEM_TIMEOUT=15 -> ERR after 15 MEM cycles; bus_err=1 sticky; cleared only by rst=1.
REQ-036 instr=0xFFFFFFFF -> with NF_CU_TRAP_EN: illegal=1, state=5; without: NOP, pc_we pulse, back to FETCH.
REQ-037 JAL followed by rst asserted in WB -> no rf_we; state=0 and i_req=1 in the cycle after rst deasserts.
